// File: rtl/shadowmask_ctrl.sv
// shadowmask_ctrl: frame-synchronous shadow-mask settings and double-buffered custom pattern loader.
module shadowmask_ctrl #(
    parameter logic [3:0] MAGIC       = 4'hA,
    parameter logic [2:0] CUSTOM_TYPE = 3'd7
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        vs_in,
    input  logic [2:0]  type_req,
    input  logic        rotate_req,
    input  logic        x2_req,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [15:0] ld_data,
    input  logic        ld_last,
    output logic [2:0]  mask_type,
    output logic        mask_rotate,
    output logic        mask_2x,
    output logic        custom_sel,
    output logic [2:0]  pat_hmax,
    output logic [1:0]  pat_vmax,
    input  logic [4:0]  rd_addr,
    output logic [2:0]  rd_data,
    output logic        ld_error
);
    typedef enum logic [1:0] {HDR, DATA, DRAIN, PEND} state_t;
    state_t state, state_d;
    logic vs_q, fs, acc, magic_ok, committed, front, err, err_d, wr_en, hdr_ld, swap;
    logic [2:0] cnt, cnt_d, hdr_h, rd_ent;
    logic [1:0] hdr_v;
    logic [11:0] rd_word;
    // Each RAM word holds the four 3-bit entries of one load word; index is {bank, word}.
    logic [11:0] ram [0:15];
    logic unused;

    assign fs         = vs_q & ~vs_in;
    assign acc        = ld_valid & ld_ready;
    assign magic_ok   = ld_data[15:12] == MAGIC;
    assign custom_sel = (mask_type == CUSTOM_TYPE) && committed;
    assign ld_error   = err;
    assign rd_word    = ram[{front, rd_addr[4:2]}];
    assign rd_ent     = rd_addr[1] ? (rd_addr[0] ? rd_word[11:9] : rd_word[8:6])
                                   : (rd_addr[0] ? rd_word[5:3]  : rd_word[2:0]);
    assign unused     = ^{ld_data[11], ld_data[7], ld_data[3]};

    always_ff @(posedge clk) begin
        if (!reset_n) state <= HDR;
        else          state <= state_d;
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        err_d   = err;
        case (state)
            HDR: if (acc) begin
                err_d   = !magic_ok;
                cnt_d   = 3'd0;
                state_d = magic_ok ? DATA : (ld_last ? HDR : DRAIN);
            end
            DATA: if (acc) begin
                cnt_d = cnt + 3'd1;
                if (ld_last && cnt == 3'd7) state_d = PEND;
                else if (ld_last) begin
                    state_d = HDR;
                    err_d   = 1'b1;
                end else if (cnt == 3'd7) begin
                    state_d = DRAIN;
                    err_d   = 1'b1;
                end
            end
            DRAIN: if (acc && ld_last) state_d = HDR;
            PEND:  if (fs) state_d = HDR;
            default: state_d = HDR;
        endcase
    end

    always_comb begin
        ld_ready = reset_n && state != PEND;
        wr_en    = acc && state == DATA;
        hdr_ld   = acc && state == HDR && magic_ok;
        swap     = state == PEND && fs;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vs_q        <= 1'b0;
            mask_type   <= 3'd0;
            mask_rotate <= 1'b0;
            mask_2x     <= 1'b0;
            committed   <= 1'b0;
            front       <= 1'b0;
            pat_hmax    <= 3'd0;
            pat_vmax    <= 2'd0;
            rd_data     <= 3'd0;
            err         <= 1'b0;
            cnt         <= 3'd0;
        end else begin
            vs_q    <= vs_in;
            rd_data <= rd_ent;
            err     <= err_d;
            cnt     <= cnt_d;
            if (fs) begin
                mask_type   <= (type_req == CUSTOM_TYPE && !committed) ? 3'd0 : type_req;
                mask_rotate <= rotate_req;
                mask_2x     <= x2_req;
            end
            if (swap) begin
                front     <= ~front;
                committed <= 1'b1;
                pat_hmax  <= hdr_h;
                pat_vmax  <= hdr_v;
            end
        end
    end

    // Pattern storage and back-bank header are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) ram[{~front, cnt}] <= {ld_data[14:12], ld_data[10:8], ld_data[6:4], ld_data[2:0]};
        if (hdr_ld) begin
            hdr_h <= ld_data[2:0];
            hdr_v <= ld_data[5:4];
        end
    end
endmodule
